// File: rtl/alu_rs.sv
// -----------------------------------------------------------------------------
// alu_rs -- reservation station in front of the ALU of the out-of-order core.
//
// Holds decoded ALU/branch/jump instructions until both source operands are
// known, snoops the ALU and LSB result broadcasts to wake waiting operands, and
// sends the lowest-index ready entry to the ALU each cycle.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   rdy                   global ready; low freezes all state and outputs
//   rollback              mispredict flush: empties the station
//   issue_*               one instruction from the decoder; each source operand
//                         comes as a value (rsN_rdy=1) or a producer ROB tag
//   rs_full               every entry busy; the decoder must not issue
//   alu_cdb_*, lsb_cdb_*  result broadcasts {en, rob tag, value}
//   alu_*                 dispatch to the ALU; alu_en pulses once per
//                         instruction, fields hold while alu_en is low
// -----------------------------------------------------------------------------
module alu_rs #(
    parameter int RS_SIZE   = 16,
    parameter int RS_IDX_W  = 4,
    parameter int ROB_POS_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 rollback,

    input  logic                 issue_en,
    input  logic [6:0]           issue_opcode,
    input  logic [2:0]           issue_funct3,
    input  logic                 issue_funct7,
    input  logic                 issue_rs1_rdy,
    input  logic [31:0]          issue_rs1_val,
    input  logic [ROB_POS_W-1:0] issue_rs1_rob,
    input  logic                 issue_rs2_rdy,
    input  logic [31:0]          issue_rs2_val,
    input  logic [ROB_POS_W-1:0] issue_rs2_rob,
    input  logic [31:0]          issue_imm,
    input  logic [31:0]          issue_pc,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,
    output logic                 rs_full,

    input  logic                 alu_cdb_en,
    input  logic [ROB_POS_W-1:0] alu_cdb_rob,
    input  logic [31:0]          alu_cdb_val,
    input  logic                 lsb_cdb_en,
    input  logic [ROB_POS_W-1:0] lsb_cdb_rob,
    input  logic [31:0]          lsb_cdb_val,

    output logic                 alu_en,
    output logic [6:0]           alu_opcode,
    output logic [2:0]           alu_funct3,
    output logic                 alu_funct7,
    output logic [31:0]          alu_val1,
    output logic [31:0]          alu_val2,
    output logic [31:0]          alu_imm,
    output logic [31:0]          alu_pc,
    output logic [ROB_POS_W-1:0] alu_rob_pos
);

    // One source operand: either a value (rdy=1) or the tag of its producer.
    typedef struct packed {
        logic                 rdy;
        logic [31:0]          val;
        logic [ROB_POS_W-1:0] tag;
    } operand_t;

    typedef struct packed {
        logic [6:0]           opcode;
        logic [2:0]           funct3;
        logic                 funct7;
        logic [31:0]          imm;
        logic [31:0]          pc;
        logic [ROB_POS_W-1:0] rob_pos;
        operand_t             op1;
        operand_t             op2;
    } entry_t;

    entry_t              ent   [RS_SIZE];
    operand_t            woke1 [RS_SIZE];
    operand_t            woke2 [RS_SIZE];
    logic [RS_SIZE-1:0]  busy;
    logic [RS_SIZE-1:0]  busy_next;
    logic [RS_SIZE-1:0]  ready;
    logic [RS_IDX_W-1:0] free_idx;
    logic [RS_IDX_W-1:0] disp_idx;
    logic                has_ready;
    logic                write_ok;
    operand_t            issue_op1_raw;
    operand_t            issue_op2_raw;
    entry_t              new_entry;
    entry_t              disp_entry;

    // Resolve a waiting operand against this cycle's broadcasts. ROB tags are
    // unique, so at most one of the two buses can match.
    function automatic operand_t snoop(input operand_t op);
        operand_t r;
        r = op;
        if (!op.rdy) begin
            if (alu_cdb_en && op.tag == alu_cdb_rob) begin
                r.rdy = 1'b1;
                r.val = alu_cdb_val;
            end else if (lsb_cdb_en && op.tag == lsb_cdb_rob) begin
                r.rdy = 1'b1;
                r.val = lsb_cdb_val;
            end
        end
        return r;
    endfunction

    assign rs_full       = &busy;
    assign write_ok      = issue_en && !rs_full;
    assign issue_op1_raw = {issue_rs1_rdy, issue_rs1_val, issue_rs1_rob};
    assign issue_op2_raw = {issue_rs2_rdy, issue_rs2_val, issue_rs2_rob};
    assign disp_entry    = ent[disp_idx];

    // Incoming instruction, with operands bypassed from same-cycle broadcasts
    // so a result produced while the consumer is being written is not missed.
    always_comb begin
        new_entry.opcode  = issue_opcode;
        new_entry.funct3  = issue_funct3;
        new_entry.funct7  = issue_funct7;
        new_entry.imm     = issue_imm;
        new_entry.pc      = issue_pc;
        new_entry.rob_pos = issue_rob_pos;
        new_entry.op1     = snoop(issue_op1_raw);
        new_entry.op2     = snoop(issue_op2_raw);
    end

    // Wakeup view of every stored entry and the ready mask. Readiness uses the
    // registered operand state only, so an operand woken at an edge dispatches
    // one cycle later.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            woke1[i] = snoop(ent[i].op1);
            woke2[i] = snoop(ent[i].op2);
            ready[i] = busy[i] && ent[i].op1.rdy && ent[i].op2.rdy;
        end
    end

    // Lowest-index free slot and lowest-index ready slot. Scanning downward
    // lets the last hit (the lowest index) win.
    // NOTE: every variable gets a default before the loop; a path that leaves
    // one unassigned would make synthesis infer a latch.
    always_comb begin
        free_idx  = '0;
        disp_idx  = '0;
        has_ready = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = RS_IDX_W'(i);
            end
            if (ready[i]) begin
                disp_idx  = RS_IDX_W'(i);
                has_ready = 1'b1;
            end
        end
    end

    // The free slot is never busy and the dispatch slot always is, so the two
    // updates below always hit different bits. A slot freed by dispatch is
    // only visible to free_idx from the next cycle on.
    always_comb begin
        busy_next = busy;
        if (rollback) begin
            busy_next = '0;
        end else begin
            if (write_ok) begin
                busy_next[free_idx] = 1'b1;
            end
            if (has_ready) begin
                busy_next[disp_idx] = 1'b0;
            end
        end
    end

    // Control state and dispatch registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            alu_en      <= 1'b0;
            alu_opcode  <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= 1'b0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_rob_pos <= '0;
        end else if (rdy) begin
            busy <= busy_next;
            if (rollback || !has_ready) begin
                alu_en <= 1'b0;
            end else begin
                alu_en      <= 1'b1;
                alu_opcode  <= disp_entry.opcode;
                alu_funct3  <= disp_entry.funct3;
                alu_funct7  <= disp_entry.funct7;
                alu_val1    <= disp_entry.op1.val;
                alu_val2    <= disp_entry.op2.val;
                alu_imm     <= disp_entry.imm;
                alu_pc      <= disp_entry.pc;
                alu_rob_pos <= disp_entry.rob_pos;
            end
        end
    end

    // Entry payload.
    // NOTE: the payload array has no reset; busy qualifies every use of it, so
    // clearing busy is enough and the storage stays plain flops/RAM.
    always_ff @(posedge clk) begin
        if (rdy && !rollback) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (write_ok && free_idx == RS_IDX_W'(i)) begin
                    ent[i] <= new_entry;
                end else begin
                    ent[i].op1 <= woke1[i];
                    ent[i].op2 <= woke2[i];
                end
            end
        end
    end

endmodule
